// File: rtl/mfp_ahb_melody_seq.sv
// Note sequencer for the buzzer: a small FIFO of (note, duration) entries played back in order,
// each note held for its duration in ms and followed by a fixed silent gap.
module mfp_ahb_melody_seq #(
  parameter int TICK_DIV = 50_000,
  parameter int DEPTH    = 8,
  parameter int DUR_W    = 12,
  parameter int GAP_MS   = 20
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [2:0]               wr_note,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic                     enable,
  input  logic                     flush,
  output logic [31:0]              note_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     done_pulse,
  output logic [1:0]               state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = DUR_W + 3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2} state_t;

  // Handshake: an entry transfers on any rising clk edge where wr_valid && wr_ready;
  // wr_valid may be held or dropped freely and is ignored while wr_ready is low.

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0] ms_q, ms_d;
  logic [2:0]       cur_note_q, cur_note_d;
  logic [2:0]       note_out_q, note_out_d;
  logic             busy_q, busy_d;
  logic             end_q, end_d;
  logic             done_q, done_d;

  logic             full, empty, push, pop, active, tick;
  logic [2:0]       head_note;
  logic [DUR_W-1:0] head_dur;

  always_comb begin
    full      = (level_q == (AW+1)'(DEPTH));
    empty     = (level_q == '0);
    wr_ready  = !full && !flush;
    push      = wr_valid && wr_ready;
    head_note = mem_q[rd_ptr_q][EW-1:DUR_W];
    head_dur  = mem_q[rd_ptr_q][DUR_W-1:0];
    active    = (state_q != S_IDLE);
    tick      = active && enable && (presc_q == PW'(TICK_DIV - 1));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_note, wr_dur};
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      presc_q    <= '0;
      ms_q       <= '0;
      cur_note_q <= '0;
      note_out_q <= '0;
      busy_q     <= 1'b0;
      end_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      presc_q    <= presc_d;
      ms_q       <= ms_d;
      cur_note_q <= cur_note_d;
      note_out_q <= note_out_d;
      busy_q     <= busy_d;
      end_q      <= end_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; the prescaler and ms counter only move while enable is high.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    ms_d       = ms_q;
    cur_note_d = cur_note_q;
    pop        = 1'b0;
    end_d      = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      presc_d = '0;
      ms_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty && enable) begin
            pop = 1'b1;
            if (head_dur != '0) begin
              state_d    = S_PLAY;
              ms_d       = head_dur;
              cur_note_d = head_note;
              presc_d    = '0;
            end
          end
        end
        S_PLAY, S_GAP: begin
          if (enable) presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (ms_q == DUR_W'(1)) begin
              presc_d = '0;
              if (state_q == S_PLAY) begin
                end_d = 1'b1;
                if (GAP_MS != 0) begin
                  state_d = S_GAP;
                  ms_d    = DUR_W'(GAP_MS);
                end else begin
                  state_d = S_IDLE;
                  ms_d    = '0;
                end
              end else begin
                state_d = S_IDLE;
                ms_d    = '0;
              end
            end else begin
              ms_d = ms_q - DUR_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    wr_ptr_d = flush ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
    rd_ptr_d = flush ? '0 : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
    level_d  = flush ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // Outputs trail the state by one register stage, so note, busy and done stay aligned.
  always_comb begin
    note_out_d = (!flush && enable && state_q == S_PLAY) ? cur_note_q : 3'd0;
    busy_d     = !flush && active;
    done_d     = !flush && end_q;
  end

  assign note_out   = {29'd0, note_out_q};
  assign busy       = busy_q;
  assign level      = level_q;
  assign done_pulse = done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mfp_ahb_melody_seq.sv
// Directed bench for mfp_ahb_melody_seq with a small clock period and short gap.
module tb_mfp_ahb_melody_seq;

  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 8;
  localparam int DUR_W    = 12;
  localparam int GAP_MS   = 2;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [2:0]       wr_note = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic             enable = 1'b0;
  logic             flush = 1'b0;
  logic [31:0]      note_out;
  logic             busy;
  logic [3:0]       level;
  logic             done_pulse;
  logic [1:0]       state_dbg;

  mfp_ahb_melody_seq #(
    .TICK_DIV(TICK_DIV), .DEPTH(DEPTH), .DUR_W(DUR_W), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_note(wr_note), .wr_dur(wr_dur), .enable(enable), .flush(flush),
    .note_out(note_out), .busy(busy), .level(level), .done_pulse(done_pulse),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          hi_cnt, done_cnt, done_cyc, gap_cnt, extra;
  int          k;
  logic        busy_prev = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic clear_stats();
    hi_cnt = 0; done_cnt = 0; done_cyc = 0; gap_cnt = 0; extra = 0;
  endtask

  // One clock: advance, then sample outputs 1 ns after the edge and score note starts.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (done_pulse) begin
      done_cnt++;
      if (done_cyc == 0) done_cyc = cyc;
    end
    if (note_out != 0) hi_cnt++;
    if (busy && note_out == 0) gap_cnt++;
    if (busy && !busy_prev) begin
      if (exp_q.size() > 0) check("order", note_out, exp_q.pop_front());
      else extra++;
    end
    busy_prev = busy;
  endtask

  task automatic push(input logic [2:0] note, input int dur);
    wr_valid = 1'b1;
    wr_note  = note;
    wr_dur   = DUR_W'(dur);
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    clear_stats();
    // 1: reset values
    repeat (3) step();
    check("rst_note", note_out, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    step();
    check("idle_note", note_out, 0);
    check("idle_busy", busy, 0);
    check("idle_level", level, 0);
    check("idle_ready", wr_ready, 1);
    check("idle_done", done_pulse, 0);
    check("idle_state", state_dbg, 0);

    // 2: single note (3,5): 20 high cycles from k+2, done at k+22, 8 gap cycles
    enable = 1'b1;
    clear_stats();
    exp_q.push_back(3);
    push(3, 5);
    k = cyc;
    check("t2_level_push", level, 1);
    step();
    check("t2_note_k1", note_out, 0);
    step();
    check("t2_note_k2", note_out, 3);
    check("t2_busy_k2", busy, 1);
    repeat (38) step();
    check("t2_hi", hi_cnt, 20);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_at", done_cyc - k, 22);
    check("t2_gap", gap_cnt, 8);
    check("t2_busy_end", busy, 0);

    // 3: fill while paused, 9th push dropped, then play 8 in order
    enable = 1'b0;
    clear_stats();
    for (int i = 0; i < 8; i++) push(3'((i % 7) + 1), 1);
    check("t3_level_full", level, 8);
    check("t3_ready_full", wr_ready, 0);
    push(2, 1);
    check("t3_level_drop", level, 8);
    check("t3_busy_paused", busy, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'((i % 7) + 1));
    enable = 1'b1;
    repeat (130) step();
    check("t3_done_cnt", done_cnt, 8);
    check("t3_hi", hi_cnt, 32);
    check("t3_level_end", level, 0);
    check("t3_pending", exp_q.size(), 0);
    check("t3_extra", extra, 0);

    // 4: 10-cycle pause mid-note (5,4): total high 16, done moves from k+18 to k+28
    clear_stats();
    exp_q.push_back(5);
    push(5, 4);
    k = cyc;
    repeat (4) step();
    enable = 1'b0;
    repeat (10) step();
    check("t4_hi_pre", hi_cnt, 3);
    check("t4_note_paused", note_out, 0);
    check("t4_busy_paused", busy, 1);
    enable = 1'b1;
    repeat (30) step();
    check("t4_hi_total", hi_cnt, 16);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_done_at", done_cyc - k, 28);

    // 5: flush during PLAY with 3 queued; push during flush is dropped
    clear_stats();
    exp_q.push_back(6);
    push(6, 5);
    push(1, 3);
    push(2, 3);
    push(3, 3);
    check("t5_level3", level, 3);
    check("t5_note_play", note_out, 6);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_note  = 3'd7;
    wr_dur   = DUR_W'(3);
    #1;
    check("t5_ready_flush", wr_ready, 0);
    step();
    check("t5_note_flush", note_out, 0);
    check("t5_level_flush", level, 0);
    check("t5_busy_flush", busy, 0);
    flush    = 1'b0;
    wr_valid = 1'b0;
    repeat (30) step();
    check("t5_done_cnt", done_cnt, 0);
    check("t5_level_end", level, 0);
    check("t5_busy_end", busy, 0);
    check("t5_extra", extra, 0);

    // 6: zero-duration entry skipped, then reset in the middle of a note
    clear_stats();
    exp_q.push_back(2);
    exp_q.push_back(6);
    push(2, 1);
    push(4, 0);
    push(6, 1);
    repeat (33) step();
    check("t6_done_cnt", done_cnt, 2);
    check("t6_hi", hi_cnt, 8);
    check("t6_pending", exp_q.size(), 0);
    check("t6_extra", extra, 0);
    exp_q.push_back(6);
    push(6, 2);
    push(1, 1);
    repeat (2) step();
    check("t6_note_mid", note_out, 6);
    resetn = 1'b0;
    #1;
    check("t6_rst_note", note_out, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_done", done_pulse, 0);
    check("t6_rst_ready", wr_ready, 1);
    check("t6_rst_state", state_dbg, 0);
    repeat (2) step();
    resetn = 1'b1;
    repeat (20) step();
    check("t6_post_level", level, 0);
    check("t6_post_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
